// File: rtl/rate_pkg.sv
// Shared types and helpers for the rate-adapting sample buffer.
// Provides the PRIME/RUN state type and the phase-accumulator width helper.
// No ports; imported by sample_rate_buffer.
package rate_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  // acc stays below freqSys, and acc + step stays below 2*freqSys,
  // so one extra bit over $clog2(freqSys) holds the pre-wrap sum.
  function automatic int accWidth(input int freqSys);
    return $clog2(freqSys) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO holding input samples until the output tick pops them.
// Latency: a push at edge E is visible at rd_data/level right after E; pop at edge.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk, rst_n (async active-low), push/wr_data, pop/rd_data (head, combinational),
//        full, empty, level (occupancy 0..DEPTH).
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only read between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sample_rate_buffer.sv
// Rate-adapting buffer: accepts samples at source pace, emits one per FREQ_OUT tick.
// Latency: tick evaluated in cycle T pops at the end of T; outValid/outData show in T+1.
// Backpressure: inReady = !full (independent of a same-cycle pop); no output backpressure.
// Ports: clk, rstN (async active-low), inValid/inData/inReady (input handshake),
//        outValid/outData (registered pulse + held sample), fillLevel (occupancy),
//        underflow (sticky, tick found FIFO empty in RUN), clrErr (sync clear, set wins).
module sample_rate_buffer
  import rate_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int FREQ_SYS = 50,
  parameter int FREQ_OUT = 10
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   inValid,
  input  logic [DATA_W-1:0]      inData,
  output logic                   inReady,
  output logic                   outValid,
  output logic [DATA_W-1:0]      outData,
  output logic [$clog2(DEPTH):0] fillLevel,
  output logic                   underflow,
  input  logic                   clrErr
);

  localparam int ACC_W       = accWidth(FREQ_SYS);
  localparam int LW          = $clog2(DEPTH) + 1;
  localparam int PRIME_LEVEL = DEPTH / 2;

  localparam logic [ACC_W-1:0] STEP    = ACC_W'(FREQ_OUT);
  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(FREQ_SYS);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              tick;
  state_t            state;
  state_t            state_next;
  logic              push;
  logic              pop;
  logic              uf_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [LW-1:0]     fifo_level;
  logic [LW:0]       level_after_push;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rstN),
    .push    (push),
    .wr_data (inData),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign inReady   = !fifo_full;
  assign push      = inValid && !fifo_full;
  assign fillLevel = fifo_level;

  // Phase accumulator: a tick fires whenever the running phase crosses FREQ_SYS,
  // giving exactly FREQ_OUT ticks per FREQ_SYS cycles with deterministic jitter.
  assign acc_sum = acc + STEP;
  assign tick    = (acc_sum >= MODULUS);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) acc <= '0;
    else       acc <= tick ? (acc_sum - MODULUS) : acc_sum;
  end

  // PRIME leaves at the same edge the threshold is crossed, so the decision
  // uses the occupancy including this cycle's push. No pops happen in PRIME.
  assign level_after_push = (LW+1)'(fifo_level) + (LW+1)'(push);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    uf_set     = 1'b0;
    case (state)
      PRIME: begin
        if (level_after_push >= (LW+1)'(PRIME_LEVEL)) state_next = RUN;
      end
      RUN: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            uf_set     = 1'b1;
            state_next = PRIME;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= PRIME;
      outValid  <= 1'b0;
      outData   <= '0;
      underflow <= 1'b0;
    end else begin
      state    <= state_next;
      outValid <= pop;
      if (pop) outData <= fifo_head;
      // A new underflow outranks a clear landing in the same cycle.
      underflow <= uf_set | (underflow & ~clrErr);
    end
  end

endmodule

// File: tb/tb_sample_rate_buffer.sv
// Self-checking bench for sample_rate_buffer: 50/10 instance (a) and 50/15 instance (b).
// Directed table, hand sequences for priming/underflow/full/jitter/reset, then random vs model.
module tb_sample_rate_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int FS    = 50;
  localparam int FO_A  = 10;
  localparam int FO_B  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, a_iv, a_ir, a_ov, a_uf, a_clr;
  logic [DW-1:0] a_id, a_od;
  logic [3:0]    a_fl;
  logic          b_rst_n, b_iv, b_ir, b_ov, b_uf, b_clr;
  logic [DW-1:0] b_id, b_od;
  logic [3:0]    b_fl;

  sample_rate_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .FREQ_SYS(FS), .FREQ_OUT(FO_A)) dut_a (
    .clk(clk), .rstN(a_rst_n), .inValid(a_iv), .inData(a_id), .inReady(a_ir),
    .outValid(a_ov), .outData(a_od), .fillLevel(a_fl), .underflow(a_uf), .clrErr(a_clr));

  sample_rate_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .FREQ_SYS(FS), .FREQ_OUT(FO_B)) dut_b (
    .clk(clk), .rstN(b_rst_n), .inValid(b_iv), .inData(b_id), .inReady(b_ir),
    .outValid(b_ov), .outData(b_od), .fillLevel(b_fl), .underflow(b_uf), .clrErr(b_clr));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_iv = 0; a_id = '0; a_clr = 0;
    a_rst_n = 0;
    step(); step();
    a_rst_n = 1;
  endtask

  task automatic reset_b();
    b_iv = 0; b_id = '0; b_clr = 0;
    b_rst_n = 0;
    step(); step();
    b_rst_n = 1;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          clr;
    logic          ev;
    logic [DW-1:0] ed;
    int            el;
    logic          eu;
    logic          er;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic clr,
                              input logic ev, input logic [DW-1:0] ed, input int el, input logic eu);
    vec_t v;
    v.iv = iv; v.id = id; v.clr = clr; v.ev = ev; v.ed = ed; v.el = el; v.eu = eu;
    v.er = (el < DEPTH);
    return v;
  endfunction

  vec_t tbl[12];

  // Reference model state (random phase, instance a).
  logic [DW-1:0] mq[$];
  logic [DW-1:0] outq[$];
  logic          m_run, m_uf, m_ov, uf_ev, tk, exp_rdy, exp_ov, rdy;
  logic [DW-1:0] m_od;
  longint        kk;
  int            src, nxt, pulses, max_lvl, p;
  int            frac_ticks[8] = '{7, 10, 14, 17, 20, 24, 27, 30};
  int            probs[4] = '{60, 15, 30, 90};

  initial begin
    a_iv = 0; a_id = '0; a_clr = 0; b_iv = 0; b_id = '0; b_clr = 0;
    a_rst_n = 1; b_rst_n = 1;
    #1 a_rst_n = 0; b_rst_n = 0;
    #1;
    // Asynchronous reset: outputs settle before any clock edge.
    check("reset outValid", 32'(a_ov), 0);
    check("reset outData", 32'(a_od), 0);
    check("reset fillLevel", 32'(a_fl), 0);
    check("reset underflow", 32'(a_uf), 0);
    check("reset inReady", 32'(a_ir), 1);

    // ---------------- directed table (cycle k = row+1) ----------------
    tbl[0]  = mk(1, 16'hA000, 0, 0, 16'h0000, 1, 0);
    tbl[1]  = mk(1, 16'hA001, 0, 0, 16'h0000, 2, 0);
    tbl[2]  = mk(1, 16'hA002, 0, 0, 16'h0000, 3, 0);
    tbl[3]  = mk(1, 16'hA003, 0, 0, 16'h0000, 4, 0);
    tbl[4]  = mk(0, 16'h0000, 0, 1, 16'hA000, 3, 0);
    tbl[5]  = mk(1, 16'hA004, 0, 0, 16'hA000, 4, 0);
    tbl[6]  = mk(0, 16'h0000, 0, 0, 16'hA000, 4, 0);
    tbl[7]  = mk(0, 16'h0000, 1, 0, 16'hA000, 4, 0);
    tbl[8]  = mk(1, 16'hA005, 0, 0, 16'hA000, 5, 0);
    tbl[9]  = mk(1, 16'hA006, 0, 1, 16'hA001, 5, 0);
    tbl[10] = mk(0, 16'h0000, 0, 0, 16'hA001, 5, 0);
    tbl[11] = mk(0, 16'h0000, 0, 0, 16'hA001, 5, 0);

    reset_a();
    for (int i = 0; i < 12; i++) begin
      a_iv = tbl[i].iv; a_id = tbl[i].id; a_clr = tbl[i].clr;
      step();
      check($sformatf("tbl[%0d] outValid", i), 32'(a_ov), 32'(tbl[i].ev));
      check($sformatf("tbl[%0d] outData", i), 32'(a_od), 32'(tbl[i].ed));
      check($sformatf("tbl[%0d] fillLevel", i), 32'(a_fl), 32'(tbl[i].el));
      check($sformatf("tbl[%0d] underflow", i), 32'(a_uf), 32'(tbl[i].eu));
      check($sformatf("tbl[%0d] inReady", i), 32'(a_ir), 32'(tbl[i].er));
    end

    // ---------------- drain to underflow, clear, set-wins ----------------
    a_iv = 0; a_clr = 0;
    for (int k = 13; k <= 40; k++) begin
      step();
      exp_ov = (k % 5 == 0) && (k <= 35);
      check($sformatf("drain c%0d outValid", k), 32'(a_ov), 32'(exp_ov));
      if (exp_ov) check($sformatf("drain c%0d outData", k), 32'(a_od), 32'(16'hA002 + (k - 15) / 5));
      check($sformatf("drain c%0d underflow", k), 32'(a_uf), 32'(k >= 40));
    end
    check("underflow holds outData", 32'(a_od), 32'h0000A006);
    a_clr = 1; step(); a_clr = 0;
    check("clrErr clears underflow", 32'(a_uf), 0);
    for (int k = 42; k <= 45; k++) begin
      a_iv = 1; a_id = 16'(16'hB000 + k - 42);
      step();
    end
    a_iv = 0;
    check("threshold-edge tick no pop outValid", 32'(a_ov), 0);
    check("threshold-edge tick no pop level", 32'(a_fl), 4);
    for (int k = 46; k <= 71; k++) begin
      a_clr = (k == 70);
      step();
      exp_ov = (k % 5 == 0) && (k >= 50) && (k <= 65);
      check($sformatf("rerun c%0d outValid", k), 32'(a_ov), 32'(exp_ov));
      if (exp_ov) check($sformatf("rerun c%0d outData", k), 32'(a_od), 32'(16'hB000 + (k - 50) / 5));
      check($sformatf("rerun c%0d underflow", k), 32'(a_uf), 32'(k >= 70));
    end
    a_clr = 0;

    // ---------------- priming with 3 samples ----------------
    reset_a();
    for (int k = 1; k <= 3; k++) begin
      a_iv = 1; a_id = 16'(16'hC000 + k - 1);
      step();
    end
    a_iv = 0;
    pulses = 0;
    for (int k = 4; k <= 23; k++) begin
      step();
      if (a_ov) pulses++;
    end
    check("prime 3 samples pulses", 32'(pulses), 0);
    check("prime 3 samples level", 32'(a_fl), 3);
    a_iv = 1; a_id = 16'hC003;
    step();
    a_iv = 0;
    check("prime 4th push level", 32'(a_fl), 4);
    for (int k = 25; k <= 40; k++) begin
      step();
      exp_ov = (k % 5 == 0);
      check($sformatf("prime c%0d outValid", k), 32'(a_ov), 32'(exp_ov));
      if (exp_ov) check($sformatf("prime c%0d outData", k), 32'(a_od), 32'(16'hC000 + (k - 25) / 5));
    end

    // ---------------- full: push every cycle ----------------
    reset_a();
    src = 0; max_lvl = 0;
    outq.delete();
    for (int k = 1; k <= 40; k++) begin
      a_iv = 1; a_id = 16'(src);
      rdy = a_ir;
      step();
      if (rdy) src++;
      if (a_ov) outq.push_back(a_od);
      if (32'(a_fl) > max_lvl) max_lvl = 32'(a_fl);
      if (k == 9) begin
        check("full level at c9", 32'(a_fl), 8);
        check("full inReady at c9", 32'(a_ir), 0);
      end
    end
    a_iv = 0;
    for (int k = 41; k <= 100; k++) begin
      step();
      if (a_ov) outq.push_back(a_od);
    end
    check("full max level", 32'(max_lvl), 8);
    check("full drained count", 32'(outq.size()), 32'(src));
    nxt = 0;
    foreach (outq[i]) if (32'(outq[i]) == 32'(i)) nxt++;
    check("full drained in order", 32'(nxt), 32'(outq.size()));
    check("full drain underflow", 32'(a_uf), 1);

    // ---------------- fractional 50/15 jitter, then async reset ----------------
    reset_b();
    src = 0; nxt = 0;
    for (int k = 1; k <= 30; k++) begin
      b_iv = 1; b_id = 16'(16'h0100 + src);
      rdy = b_ir;
      step();
      if (rdy) src++;
      exp_ov = 0;
      foreach (frac_ticks[j]) if (frac_ticks[j] == k) exp_ov = 1;
      check($sformatf("frac c%0d outValid", k), 32'(b_ov), 32'(exp_ov));
      if (exp_ov) begin
        check($sformatf("frac c%0d outData", k), 32'(b_od), 32'(16'h0100 + nxt));
        nxt++;
      end
    end
    check("frac pop count", 32'(nxt), 8);
    #2 b_rst_n = 0;
    #1;
    check("midrun reset outValid", 32'(b_ov), 0);
    check("midrun reset outData", 32'(b_od), 0);
    check("midrun reset fillLevel", 32'(b_fl), 0);
    check("midrun reset underflow", 32'(b_uf), 0);
    check("midrun reset inReady", 32'(b_ir), 1);
    b_iv = 0;
    step();
    b_rst_n = 1;

    // ---------------- random stimulus against reference model ----------------
    reset_a();
    mq.delete();
    m_run = 0; m_uf = 0; m_ov = 0; m_od = '0; kk = 0;
    for (int ph = 0; ph < 4; ph++) begin
      p = probs[ph];
      for (int n = 0; n < 250; n++) begin
        kk++;
        a_iv  = ($urandom_range(0, 99) < p);
        a_id  = 16'($urandom);
        a_clr = ($urandom_range(0, 15) == 0);
        exp_rdy = (mq.size() < DEPTH);
        check("rnd inReady", 32'(a_ir), 32'(exp_rdy));
        // Tick k is due when floor(k*FO/FS) advances.
        tk = ((kk * FO_A) / FS) != (((kk - 1) * FO_A) / FS);
        step();
        m_ov = 0; uf_ev = 0;
        if (m_run && tk) begin
          if (mq.size() > 0) begin
            m_od = mq.pop_front();
            m_ov = 1;
          end else begin
            uf_ev = 1;
          end
        end
        if (a_iv && exp_rdy) mq.push_back(a_id);
        if (uf_ev) m_uf = 1;
        else if (a_clr) m_uf = 0;
        if (uf_ev) m_run = 0;
        else if (!m_run && mq.size() >= DEPTH / 2) m_run = 1;
        check("rnd outValid", 32'(a_ov), 32'(m_ov));
        check("rnd outData", 32'(a_od), 32'(m_od));
        check("rnd fillLevel", 32'(a_fl), 32'(mq.size()));
        check("rnd underflow", 32'(a_uf), 32'(m_uf));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
